// File: rtl/dds_ddc_center_mul_arbiter.sv
// Round-robin arbiter sharing one 3-stage 16u x 18s multiplier among NUM_REQ requesters.
// A tag pipeline keeps each product's requester ID aligned with the multiplier stages.
module dds_ddc_center_mul_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ID_W       = $clog2(NUM_REQ),
    parameter int PIPE_DEPTH = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ*16-1:0] req_a,
    input  logic [NUM_REQ*18-1:0] req_b,
    output logic                  mul_ce,
    output logic [15:0]           mul_din0,
    output logic [17:0]           mul_din1,
    input  logic [33:0]           mul_dout,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [ID_W-1:0]       rsp_id,
    output logic [33:0]           rsp_p,
    output logic                  idle
);

    logic [ID_W-1:0]       ptr;
    logic [PIPE_DEPTH-1:0] vld;
    logic [ID_W-1:0]       id_pipe [PIPE_DEPTH];
    logic                  found;
    logic [ID_W-1:0]       gnt_idx;
    logic                  gnt;

    // Gating with reset keeps stale multiplier output from ever looking valid.
    assign rsp_valid = vld[PIPE_DEPTH-1] && !reset;
    assign rsp_id    = id_pipe[PIPE_DEPTH-1];
    assign rsp_p     = mul_dout;
    assign mul_ce    = !(rsp_valid && !rsp_ready) && !reset;
    assign idle      = !reset && !(|vld) && !(|req_valid);

    always_comb begin : grant_search
        int              idx;
        logic [ID_W-1:0] cand;
        idx     = 0;
        cand    = '0;
        found   = 1'b0;
        gnt_idx = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            cand = ID_W'(idx);
            if (!found && req_valid[cand]) begin
                found   = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    always_comb begin
        gnt       = found && mul_ce;
        req_ready = '0;
        mul_din0  = '0;
        mul_din1  = '0;
        if (gnt) begin
            req_ready[gnt_idx] = 1'b1;
            mul_din0           = req_a[16*gnt_idx +: 16];
            mul_din1           = req_b[18*gnt_idx +: 18];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= ID_W'(NUM_REQ - 1);
            vld <= '0;
        end else if (mul_ce) begin
            vld <= {vld[PIPE_DEPTH-2:0], gnt};
            if (gnt) begin
                ptr <= gnt_idx;
            end
        end
    end

    // IDs need no reset: vld alone decides whether a stage carries a product.
    always_ff @(posedge clk) begin
        if (mul_ce) begin
            id_pipe[0] <= gnt_idx;
            for (int s = 1; s < PIPE_DEPTH; s++) begin
                id_pipe[s] <= id_pipe[s-1];
            end
        end
    end

endmodule
